// File: rtl/tmds_pkg.sv
// Shared types and TMDS symbol constants for the DVI transmit sequencer.
package tmds_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK,
        SER_RST,
        SETTLE,
        WAIT_FRAME,
        RUN
    } state_t;

    // Indexed by {C1,C0}
    localparam logic [9:0] TMDS_CTL [0:3] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    localparam logic [9:0]  GUARD_L0   = 10'b1011001100;
    localparam logic [9:0]  GUARD_L1   = 10'b0100110011;
    localparam logic [9:0]  GUARD_L2   = 10'b1011001100;
    localparam logic [9:0]  CLK_WORD   = 10'b0000011111;
    localparam logic [29:0] IDLE_WORDS = {3{10'b1101010100}};

    localparam int GUARD_LEN   = 10;  // preamble + guard band, cycles
    localparam int GUARD_BAND  = 2;
    localparam int GUARD_QUIET = 12;  // minimum blank before a guarded edge

    typedef struct packed {
        logic        de;
        logic        hs;
        logic        vs;
        logic [29:0] enc;
    } vid_t;

    function automatic logic [9:0] ctl_word(input logic c1, input logic c0);
        return TMDS_CTL[{c1, c0}];
    endfunction

endpackage

// File: rtl/tmds_lock_filter.sv
// PLL lock synchronizer and run-length qualifier; counts only while armed.
module tmds_lock_filter #(
    parameter int LOCK_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pll_lock,
    input  logic arm,
    output logic lock_ok,
    output logic lock_lost
);
    localparam int CW = $clog2(LOCK_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(LOCK_CYCLES - 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          lock_s;

    assign lock_s = sync[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync <= '0;
            cnt  <= '0;
        end else begin
            sync <= {sync[0], pll_lock};
            if (!arm || !lock_s)
                cnt <= '0;
            else if (cnt != LAST)
                cnt <= cnt + 1'b1;
        end
    end

    assign lock_ok   = arm && lock_s && (cnt == LAST);
    assign lock_lost = !lock_s;

endmodule

// File: rtl/tmds_ser_sequencer.sv
// DVI link bring-up sequencer and serializer word mux.
// Define VIDEO_GUARD_EN for the 10-stage video delay with preamble/guard-band insertion.
module tmds_ser_sequencer
    import tmds_pkg::*;
#(
    parameter int LOCK_CYCLES   = 1024,
    parameter int RST_CYCLES    = 16,
    parameter int SETTLE_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pll_lock,
    input  logic        de,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [29:0] enc_word,
    output logic [29:0] ser_d,
    output logic [9:0]  clk_word,
    output logic        ser_reset,
    output logic        out_en,
    output logic        tx_ready
);
    localparam int PMAX = (RST_CYCLES > SETTLE_CYCLES) ? RST_CYCLES : SETTLE_CYCLES;
    localparam int PW   = $clog2(PMAX + 1);

    state_t        state, state_nx;
    logic [PW-1:0] pcnt, pcnt_nx;
    logic          vs_q, vs_rise;
    logic          lock_ok, lock_lost;
    logic [29:0]   vword;

    tmds_lock_filter #(.LOCK_CYCLES(LOCK_CYCLES)) u_lock (
        .clk       (clk),
        .reset_n   (reset_n),
        .pll_lock  (pll_lock),
        .arm       (state == WAIT_LOCK),
        .lock_ok   (lock_ok),
        .lock_lost (lock_lost)
    );

    // vs_q tracks vsync in every state so an edge on the WAIT_FRAME entry cycle is seen
    assign vs_rise = vsync && !vs_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= WAIT_LOCK;
            pcnt  <= '0;
            vs_q  <= 1'b0;
        end else begin
            state <= state_nx;
            pcnt  <= pcnt_nx;
            vs_q  <= vsync;
        end
    end

    always_comb begin
        state_nx = state;
        pcnt_nx  = pcnt;
        case (state)
            WAIT_LOCK: if (lock_ok) begin
                state_nx = SER_RST;
                pcnt_nx  = '0;
            end
            SER_RST: if (pcnt == PW'(RST_CYCLES - 1)) begin
                state_nx = SETTLE;
                pcnt_nx  = '0;
            end else begin
                pcnt_nx = pcnt + 1'b1;
            end
            SETTLE: if (pcnt == PW'(SETTLE_CYCLES - 1)) begin
                state_nx = WAIT_FRAME;
                pcnt_nx  = '0;
            end else begin
                pcnt_nx = pcnt + 1'b1;
            end
            WAIT_FRAME: if (vs_rise) state_nx = RUN;
            RUN: ;
            default: state_nx = WAIT_LOCK;
        endcase
        if (state != WAIT_LOCK && lock_lost) begin
            state_nx = WAIT_LOCK;
            pcnt_nx  = '0;
        end
    end

    assign ser_reset = (state == WAIT_LOCK) || (state == SER_RST);
    assign out_en    = (state == RUN);
    assign tx_ready  = (state == RUN);
    assign clk_word  = CLK_WORD;

`ifdef VIDEO_GUARD_EN
    vid_t [9:0] dl;
    vid_t       vin;
    logic [3:0] lo_cnt, g_cnt;
    logic       g_start;

    assign vin = {de, hsync, vsync, enc_word};
    // A qualifying edge seen at the input is exactly GUARD_LEN cycles ahead of dl[9]
    assign g_start = de && (lo_cnt == 4'(GUARD_QUIET));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dl     <= '0;
            lo_cnt <= '0;
            g_cnt  <= '0;
        end else if (lock_lost) begin
            dl     <= '0;
            lo_cnt <= '0;
            g_cnt  <= '0;
        end else begin
            dl     <= {dl[8:0], vin};
            lo_cnt <= de ? '0 : ((lo_cnt == 4'(GUARD_QUIET)) ? lo_cnt : lo_cnt + 4'd1);
            g_cnt  <= g_start ? 4'(GUARD_LEN - 1) : ((g_cnt != '0) ? g_cnt - 4'd1 : '0);
        end
    end

    always_comb begin
        vword = {TMDS_CTL[0], TMDS_CTL[0], ctl_word(dl[9].vs, dl[9].hs)};
        if (dl[9].de)
            vword = dl[9].enc;
        else if (g_start || g_cnt > 4'(GUARD_BAND))
            vword = {TMDS_CTL[0], TMDS_CTL[1], ctl_word(dl[9].vs, dl[9].hs)};
        else if (g_cnt != '0)
            vword = {GUARD_L2, GUARD_L1, GUARD_L0};
    end
`else
    assign vword = de ? enc_word : {TMDS_CTL[0], TMDS_CTL[0], ctl_word(vsync, hsync)};
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ser_d <= IDLE_WORDS;
        else
            ser_d <= (state == RUN && !lock_lost) ? vword : IDLE_WORDS;
    end

endmodule

// File: tb/tb_tmds_ser_sequencer.sv
// Self-checking bench for tmds_ser_sequencer: lock-timeline model plus directed literal checks.
module tb_tmds_ser_sequencer;
    localparam int L = 8, R = 4, S = 6;
`ifdef VIDEO_GUARD_EN
    localparam int LAT = 11;
`else
    localparam int LAT = 1;
`endif
    localparam logic [29:0] IDLE = 30'h354D5354;
    localparam int HN = 4096;

    logic clk = 1'b0, reset_n = 1'b0, pll_lock = 1'b0;
    logic de = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [29:0] enc_word = '0;
    logic [29:0] ser_d;
    logic [9:0]  clk_word;
    logic        ser_reset, out_en, tx_ready;

    int checks = 0, passes = 0;

    always #5 clk = ~clk;

    tmds_ser_sequencer #(.LOCK_CYCLES(L), .RST_CYCLES(R), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .reset_n(reset_n), .pll_lock(pll_lock), .de(de), .hsync(hsync),
        .vsync(vsync), .enc_word(enc_word), .ser_d(ser_d), .clk_word(clk_word),
        .ser_reset(ser_reset), .out_en(out_en), .tx_ready(tx_ready)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [9:0] ctl(input logic c1, input logic c0);
        case ({c1, c0})
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    // Input history, indexed by cycle number
    bit          de_h [0:HN-1];
    bit          hs_h [0:HN-1];
    bit          vs_h [0:HN-1];
    logic [29:0] enc_h[0:HN-1];

    // What a RUN cycle c should put on the lanes, from the input history
    function automatic logic [29:0] exp_word(input int c);
        int t, first, idx;
        bit quiet;
`ifdef VIDEO_GUARD_EN
        t = c - 10;
        if (t < 0) return IDLE;
        if (de_h[t]) return enc_h[t];
        first = 0;
        for (int k = 1; k <= 10; k++)
            if (first == 0 && de_h[t + k]) first = k;
        quiet = (first != 0);
        for (int j = 1; j <= 12; j++) begin
            idx = t + first - j;
            if (first != 0 && idx >= 0 && de_h[idx]) quiet = 0;
        end
        if (quiet && first >= 3) return {10'b1101010100, 10'b0010101011, ctl(vs_h[t], hs_h[t])};
        if (quiet) return {10'b1011001100, 10'b0100110011, 10'b1011001100};
        return {10'b1101010100, 10'b1101010100, ctl(vs_h[t], hs_h[t])};
`else
        t = c; first = 0; idx = 0; quiet = 0;
        if (de_h[t]) return enc_h[t];
        return {10'b1101010100, 10'b1101010100, ctl(vs_h[t], hs_h[t])};
`endif
    endfunction

    // Link model: the phase is a function of how long synchronized lock has been high
    int          h = 0, n = 0;
    bit          run = 0, p1 = 0, p2 = 0, vs_prev = 0;
    logic [29:0] e_ser_d = IDLE;
    bit          e_rst = 1, e_run = 0;

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                h = 0; n = 0; run = 0; p1 = 0; p2 = 0; vs_prev = 0;
                e_ser_d = IDLE; e_rst = 1; e_run = 0;
            end else begin
                bit ls, late, rise;
                ls   = p2;
                late = (h >= L + R + S);
                if (n < HN) begin
                    de_h[n] = de; hs_h[n] = hsync; vs_h[n] = vsync; enc_h[n] = enc_word;
                end
                rise    = vsync && !vs_prev;
                e_ser_d = (run && late && ls) ? exp_word(n) : IDLE;
                run     = ls && late && (run || rise);
                h       = ls ? h + 1 : 0;
                e_rst   = (h < L + R);
                e_run   = run;
                p2 = p1; p1 = pll_lock; vs_prev = vsync;
                n++;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n) begin
                chk("model_ser_d", {2'b0, ser_d}, {2'b0, e_ser_d});
                chk("model_ser_reset", {31'b0, ser_reset}, {31'b0, e_rst});
                chk("model_out_en", {31'b0, out_en}, {31'b0, e_run});
                chk("model_tx_ready", {31'b0, tx_ready}, {31'b0, e_run});
            end
        end
    end

    task automatic wait_fall(input int start, output int cnt);
        cnt = start;
        while (ser_reset && cnt < 400) begin
            @(posedge clk);
            @(negedge clk);
            cnt++;
        end
    endtask

    int nf;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_ser_reset", {31'b0, ser_reset}, 32'd1);
        chk("rst_out_en", {31'b0, out_en}, 32'd0);
        chk("rst_tx_ready", {31'b0, tx_ready}, 32'd0);
        chk("rst_ser_d", {2'b0, ser_d}, {2'b0, IDLE});
        chk("clk_word", {22'b0, clk_word}, 32'h01F);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Bring-up: release 2 + 8 + 4 edges after lock
        pll_lock = 1'b1;
        wait_fall(0, nf);
        chk("lock_to_release", nf, 32'd14);
        chk("settle_idle", {2'b0, ser_d}, {2'b0, IDLE});
        repeat (10) @(negedge clk);
        chk("wait_frame_not_ready", {31'b0, tx_ready}, 32'd0);
        chk("wait_frame_idle", {2'b0, ser_d}, {2'b0, IDLE});
        vsync = 1'b1;
        @(negedge clk);
        chk("run_entry", {31'b0, tx_ready}, 32'd1);
        chk("run_out_en", {31'b0, out_en}, 32'd1);

        // Control and video words in RUN
        vsync = 1'b0; hsync = 1'b1; de = 1'b0;
        repeat (LAT) @(negedge clk);
        chk("hsync_ctl", {2'b0, ser_d}, {2'b0, 30'h354D50AB});
        hsync = 1'b0; de = 1'b1; enc_word = 30'h2AAAAAAA;
        repeat (LAT) @(negedge clk);
        chk("video_word", {2'b0, ser_d}, {2'b0, 30'h2AAAAAAA});
        for (int i = 0; i < 24; i++) begin
            de = (i % 8) < 5; hsync = i[1]; vsync = i[2];
            enc_word = 30'h0ABCDEF0 ^ (30'(i) * 30'h01234567);
            @(negedge clk);
        end
        de = 1'b1; hsync = 1'b0; vsync = 1'b0; enc_word = 30'h2AAAAAAA;
        repeat (12) @(negedge clk);

        // Lock loss mid-line
        pll_lock = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("run_before_loss", {31'b0, tx_ready}, 32'd1);
        @(negedge clk);
        chk("loss_tx_ready", {31'b0, tx_ready}, 32'd0);
        chk("loss_out_en", {31'b0, out_en}, 32'd0);
        chk("loss_ser_reset", {31'b0, ser_reset}, 32'd1);
        chk("loss_ser_d", {2'b0, ser_d}, {2'b0, IDLE});
        de = 1'b0; enc_word = '0;
        repeat (4) @(negedge clk);

        // Relock with a one-cycle glitch at debounce count 5
        pll_lock = 1'b1;
        repeat (5) @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        pll_lock = 1'b1;
        wait_fall(6, nf);
        chk("glitch_release", nf, 32'd20);
        vsync = 1'b1;
        repeat (12) @(negedge clk);
        chk("settle_vsync_ignored", {31'b0, tx_ready}, 32'd0);
        vsync = 1'b0;
        repeat (2) @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        chk("rearm_run", {31'b0, tx_ready}, 32'd1);

`ifdef VIDEO_GUARD_EN
        de = 1'b0; hsync = 1'b0;
        repeat (20) @(negedge clk);
        de = 1'b1; enc_word = 30'h0F0F0F0F;
        @(negedge clk);
        chk("preamble_lane1", {22'b0, ser_d[19:10]}, 32'h0AB);
        chk("preamble_lane0", {22'b0, ser_d[9:0]}, 32'h154);
        repeat (8) @(negedge clk);
        chk("guard_band", {2'b0, ser_d}, {2'b0, 30'h2CC4CECC});
        repeat (2) @(negedge clk);
        chk("guarded_video", {2'b0, ser_d}, {2'b0, 30'h0F0F0F0F});
        repeat (8) @(negedge clk);
        de = 1'b0;
        repeat (6) @(negedge clk);
        de = 1'b1;
        repeat (5) @(negedge clk);
        chk("short_blank_no_preamble", {22'b0, ser_d[19:10]}, 32'h354);
        repeat (4) @(negedge clk);
        chk("short_blank_no_guard", {22'b0, ser_d[9:0]}, 32'h154);
`endif
        repeat (15) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
